// File: rtl/mul32_iter_if.sv
// Operand/result bundle for the iterative multiplier.
// master drives operands and start; slave (the multiplier) returns status and product.
interface mul32_iter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] operandA;
  logic [WIDTH-1:0] operandB;
  logic             signedOp;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] productLo;
  logic [WIDTH-1:0] productHi;
  logic             overflow;

  modport master (
    output start, operandA, operandB, signedOp,
    input  busy, done, productLo, productHi, overflow
  );

  modport slave (
    input  start, operandA, operandB, signedOp,
    output busy, done, productLo, productHi, overflow
  );
endinterface

// File: rtl/mul32_iter.sv
// Iterative shift-add multiplier: one partial-product bit per clock, fixed WIDTH-cycle latency.
// Optional signed support is compiled in with the SIGNED_MULT_EN macro.
module mul32_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic          clk,
  input logic          rst,
  mul32_iter_if.slave  bus
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} mulStateE;

  mulStateE         stateQ, stateD;
  logic [PW-1:0]    mcandQ, mcandD;
  logic [WIDTH-1:0] mplierQ, mplierD;
  logic [PW-1:0]    accQ, accD;
  logic [CNT_W-1:0] cntQ, cntD;
  logic [PW-1:0]    prodQ, prodD;
  logic             ovfQ, ovfD;

  logic [WIDTH-1:0] magA, magB;
  logic [PW-1:0]    accStep, finalProd;
  logic             finalOvf;

`ifdef SIGNED_MULT_EN
  logic negQ, negD;
  logic sgnQ, sgnD;

  // The most negative value negates to itself, which read as unsigned is its true magnitude.
  assign magA = (bus.signedOp && bus.operandA[WIDTH-1]) ? -bus.operandA : bus.operandA;
  assign magB = (bus.signedOp && bus.operandB[WIDTH-1]) ? -bus.operandB : bus.operandB;
  assign finalProd = negQ ? -accStep : accStep;
  assign finalOvf  = sgnQ ? (finalProd[PW-1:WIDTH] != {WIDTH{finalProd[WIDTH-1]}})
                          : (finalProd[PW-1:WIDTH] != '0);
`else
  logic unusedSignedOp;

  assign unusedSignedOp = bus.signedOp;
  assign magA      = bus.operandA;
  assign magB      = bus.operandB;
  assign finalProd = accStep;
  assign finalOvf  = (finalProd[PW-1:WIDTH] != '0);
`endif

  assign accStep = mplierQ[0] ? accQ + mcandQ : accQ;

  always_comb begin
    stateD  = stateQ;
    mcandD  = mcandQ;
    mplierD = mplierQ;
    accD    = accQ;
    cntD    = cntQ;
    prodD   = prodQ;
    ovfD    = ovfQ;
`ifdef SIGNED_MULT_EN
    negD    = negQ;
    sgnD    = sgnQ;
`endif
    unique case (stateQ)
      StIdle: begin
        if (bus.start) begin
          mcandD  = {{WIDTH{1'b0}}, magA};
          mplierD = magB;
          accD    = '0;
          cntD    = '0;
          stateD  = StRun;
`ifdef SIGNED_MULT_EN
          sgnD    = bus.signedOp;
          negD    = bus.signedOp & (bus.operandA[WIDTH-1] ^ bus.operandB[WIDTH-1]);
`endif
        end
      end
      StRun: begin
        accD    = accStep;
        mcandD  = mcandQ << 1;
        mplierD = mplierQ >> 1;
        cntD    = cntQ + 1'b1;
        if (cntQ == LastCnt) begin
          prodD  = finalProd;
          ovfD   = finalOvf;
          stateD = StDone;
        end
      end
      StDone:  stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ  <= StIdle;
      mcandQ  <= '0;
      mplierQ <= '0;
      accQ    <= '0;
      cntQ    <= '0;
      prodQ   <= '0;
      ovfQ    <= 1'b0;
`ifdef SIGNED_MULT_EN
      negQ    <= 1'b0;
      sgnQ    <= 1'b0;
`endif
    end else begin
      stateQ  <= stateD;
      mcandQ  <= mcandD;
      mplierQ <= mplierD;
      accQ    <= accD;
      cntQ    <= cntD;
      prodQ   <= prodD;
      ovfQ    <= ovfD;
`ifdef SIGNED_MULT_EN
      negQ    <= negD;
      sgnQ    <= sgnD;
`endif
    end
  end

  assign bus.busy      = (stateQ == StRun);
  assign bus.done      = (stateQ == StDone);
  assign bus.productLo = prodQ[WIDTH-1:0];
  assign bus.productHi = prodQ[PW-1:WIDTH];
  assign bus.overflow  = ovfQ;

endmodule

// File: tb/tb_mul32_iter.sv
// Directed bench for mul32_iter: latency, results, start filtering, reset abort, back-to-back.
module tb_mul32_iter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] lastProd = '0;

  always #5 clk = ~clk;

  mul32_iter_if #(.WIDTH(32)) bus ();

  mul32_iter #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Returns at the falling edge right after the accepting rising edge.
  task automatic startOp(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    bus.operandA = a;
    bus.operandB = b;
    bus.signedOp = s;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.operandA = $urandom;
    bus.operandB = $urandom;
    bus.signedOp = 1'b0;
  endtask

  task automatic waitDone(output int busyCnt, output bit seen);
    busyCnt = 0;
    seen    = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (bus.done) seen = 1'b1;
      else begin
        if (bus.busy) busyCnt++;
        @(negedge clk);
      end
    end
  endtask

  task automatic runMul(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [63:0] expProd, input logic expOvf);
    int busyCnt;
    bit seen;
    startOp(a, b, s);
    chk({tag, "/hold"}, {bus.productHi, bus.productLo}, lastProd);
    waitDone(busyCnt, seen);
    chk({tag, "/done"}, 64'(seen), 64'd1);
    chk({tag, "/busyCycles"}, 64'(busyCnt), 64'd32);
    chk({tag, "/prod"}, {bus.productHi, bus.productLo}, expProd);
    chk({tag, "/ovf"}, 64'(bus.overflow), 64'(expOvf));
    @(negedge clk);
    chk({tag, "/donePulse"}, 64'(bus.done), 64'd0);
    lastProd = expProd;
  endtask

  initial begin
    int  busyCnt;
    bit  seen;
    int  doneCnt;
    int  rise1, rise2;
    logic prevBusy;

    bus.start    = 1'b0;
    bus.operandA = '0;
    bus.operandB = '0;
    bus.signedOp = 1'b0;

    // Reset for two cycles, then release.
    repeat (2) @(negedge clk);
    chk("rst/busy", 64'(bus.busy), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst/prod", {bus.productHi, bus.productLo}, 64'd0);
    chk("rst/flags", {61'd0, bus.busy, bus.done, bus.overflow}, 64'd0);

    runMul("3x5", 32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F, 1'b0);
    runMul("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b1);
    runMul("zero", 32'd0, 32'h1234_5678, 1'b0, 64'd0, 1'b0);

    // start pulse mid-RUN must be ignored.
    startOp(32'd7, 32'd6, 1'b0);
    repeat (5) @(negedge clk);
    bus.start    = 1'b1;
    bus.operandA = 32'd1;
    bus.operandB = 32'd1;
    @(negedge clk);
    bus.start = 1'b0;
    waitDone(busyCnt, seen);
    chk("ignore/done", 64'(seen), 64'd1);
    chk("ignore/prod", {bus.productHi, bus.productLo}, 64'h2A);
    @(negedge clk);
    chk("ignore/noRestart", {62'd0, bus.busy, bus.done}, 64'd0);
    lastProd = 64'h2A;

    // Reset at iteration 10 abandons the multiply.
    startOp(32'd9, 32'd9, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort/prod", {bus.productHi, bus.productLo}, 64'd0);
    chk("abort/flags", {61'd0, bus.busy, bus.done, bus.overflow}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    doneCnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) doneCnt++;
    end
    chk("abort/noDone", 64'(doneCnt), 64'd0);
    lastProd = '0;
    runMul("2x2", 32'd2, 32'd2, 1'b0, 64'd4, 1'b0);

    // start held high: accepts spaced exactly 34 edges apart.
    @(negedge clk);
    bus.operandA = 32'd5;
    bus.operandB = 32'd7;
    bus.start    = 1'b1;
    prevBusy = 1'b0;
    doneCnt  = 0;
    rise1    = -1;
    rise2    = -1;
    for (int n = 1; n <= 70; n++) begin
      @(negedge clk);
      if (bus.busy && !prevBusy) begin
        if (rise1 < 0) rise1 = n;
        else if (rise2 < 0) rise2 = n;
      end
      if (bus.done) doneCnt++;
      prevBusy = bus.busy;
    end
    bus.start = 1'b0;
    chk("b2b/spacing", 64'(rise2 - rise1), 64'd34);
    chk("b2b/doneCount", 64'(doneCnt), 64'd2);
    chk("b2b/prod", {bus.productHi, bus.productLo}, 64'd35);
    waitDone(busyCnt, seen);
    chk("b2b/drain", 64'(seen), 64'd1);
    @(negedge clk);
    lastProd = 64'd35;

`ifdef SIGNED_MULT_EN
    runMul("sgnNeg3x5", 32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
    runMul("sgnNeg4xNeg5", 32'hFFFF_FFFC, 32'hFFFF_FFFB, 1'b1, 64'd20, 1'b0);
    runMul("sgnMinxNeg1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_8000_0000, 1'b1);
`endif
    runMul("unsFFFD", 32'hFFFF_FFFD, 32'd5, 1'b0, 64'h0000_0004_FFFF_FFF1, 1'b1);
`ifndef SIGNED_MULT_EN
    // Without signed support signedOp has no effect.
    runMul("ignoredSgn", 32'hFFFF_FFFD, 32'd5, 1'b1, 64'h0000_0004_FFFF_FFF1, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
